// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg: shared types and defaults for the fetch/data memory arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   localparam logic SEL_IF = 1'b0;
   localparam logic SEL_D  = 1'b1;

   localparam int DEF_MEM_SIZE = 64;
   localparam int DEF_MAX_WAIT = 4;

   // Counter must be able to hold MAX_WAIT itself (saturation value).
   function automatic int wait_width(input int max_wait);
      return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_addr_check.sv
// ---------------------------------------------------------------------------
// mem_addr_check: flags misaligned or out-of-range word accesses.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_addr_check #(
   parameter int MEM_SIZE = 64
) (
   input  logic [31:0] addr,
   output logic        fault
);

   logic [31:0] w_word_idx;

   assign w_word_idx = {2'b00, addr[31:2]};
   assign fault      = (addr[1:0] != 2'b00) || (w_word_idx >= 32'(MEM_SIZE));

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter: shares one memory port between fetch and load/store.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_SIZE = DEF_MEM_SIZE,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int                WAIT_W   = wait_width(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   arb_state_e        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              sel_q, sel_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       d_rdata_q, d_rdata_d;
   logic              err_q, err_d;

   logic              w_fault;
   logic              w_grant;
   logic [31:0]       w_rd;

   mem_addr_check #(
      .MEM_SIZE (MEM_SIZE)
   ) u_addr_check (
      .addr  (addr_q),
      .fault (w_fault)
   );

   // Faulting accesses and stores never expose memory contents.
   assign w_rd = (w_fault || we_q) ? 32'd0 : mem_rdata;

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      sel_d      = sel_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      err_d      = err_q;
      w_grant    = 1'b0;

      case (state_q)
         IDLE: begin
            if (d_req && (wait_q < WAIT_MAX)) begin
               w_grant = 1'b1;
               sel_d   = SEL_D;
               if (if_req) begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end else if (if_req) begin
               w_grant = 1'b1;
               sel_d   = SEL_IF;
               wait_d  = '0;
            end else if (d_req) begin
               w_grant = 1'b1;
               sel_d   = SEL_D;
            end

            if (w_grant) begin
               state_d = ACCESS;
               if (sel_d == SEL_D) begin
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
                  we_d    = d_we;
               end else begin
                  addr_d  = if_addr;
                  we_d    = 1'b0;
               end
            end
         end

         ACCESS: begin
            state_d = RESP;
            err_d   = w_fault;
            if (sel_q == SEL_D) begin
               d_rdata_d = w_rd;
            end else begin
               if_rdata_d = w_rd;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wait_q     <= '0;
         sel_q      <= SEL_IF;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         sel_q      <= sel_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         err_q      <= err_d;
      end
   end

   assign if_ack    = (state_q == RESP) && (sel_q == SEL_IF);
   assign d_ack     = (state_q == RESP) && (sel_q == SEL_D);
   assign if_err    = if_ack && err_q;
   assign d_err     = d_ack && err_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   // Gating by rst_n blocks a write in the very cycle reset is asserted.
   assign mem_we = rst_n && (state_q == ACCESS) && (sel_q == SEL_D) && we_q && !w_fault;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the unified single-port instruction/data memory between two requesters: the instruction-fetch port (read-only) and the load/store data port.
- Sits between the multicycle core's fetch/LSU interfaces and the memory.
- Memory read is combinational; memory write is synchronous.
- Arbitration uses fixed data-over-fetch priority with an anti-starvation counter.
- Performs alignment and range checks before any memory access.

Parameters:
- MEM_SIZE, 64, memory depth in 32-bit words; valid word index range is 0..MEM_SIZE-1.
- MAX_WAIT, 4, number of consecutive lost arbitrations after which fetch is forced to win.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch byte address
- if_ack  out  1  one-cycle completion pulse for fetch
- if_rdata  out  32  fetched word; valid while if_ack=1
- if_err  out  1  fetch fault; valid while if_ack=1
- d_req  in  1  data request; held with its fields until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle completion pulse for data
- d_rdata  out  32  load data; valid while d_ack=1
- d_err  out  1  data fault; valid while d_ack=1
- mem_addr  out  32  byte address to memory
- mem_we  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory combinational read data

Behaviour:
- Reset state (rst_n=0 at a clock edge):
  - FSM goes to IDLE; wait counter = 0.
  - All outputs = 0.
  - mem_we is also gated combinationally by rst_n, so no write occurs in a cycle where rst_n=0, even mid-ACCESS.
  - An in-flight transaction is dropped without an ack; the requester re-issues it.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If d_req and wait<MAX_WAIT: select data; if if_req is also high, wait increments.
  - Else if if_req: select fetch; wait resets to 0.
  - Else if d_req (wait==MAX_WAIT with no if_req): select data.
  - The selected request's fields are captured into holding registers; the FSM moves to ACCESS.
  - With no request, the FSM stays in IDLE.
- Fault check on the captured address: fault if addr[1:0]!=0 or addr[31:2]>=MEM_SIZE.
- ACCESS (one cycle):
  - mem_addr = captured address; mem_wdata = captured write data.
  - mem_we = 1 only for a data store with no fault.
  - mem_rdata is registered into the selected port's rdata register; 0 is registered instead on a fault or a store.
  - The fault flag is registered; the FSM moves to RESP.
- RESP (one cycle):
  - The selected port's ack = 1, together with its rdata and err; the other port's ack stays 0.
  - Requests are ignored during RESP; the FSM returns to IDLE.
- Outside ACCESS: mem_we = 0; mem_addr and mem_wdata hold their last values.
- Timing:
  - Latency is a fixed 2 cycles: request sampled at edge N, ack high during cycle N+2.
  - Maximum throughput is one transaction per 3 cycles.
- Requester obligations:
  - Keep req and its fields stable until ack.
  - Deassert req, or present a new request, in the cycle after ack.
- The wait counter saturates at MAX_WAIT and never wraps.
- Simultaneous requests follow the IDLE priority rules. Fetch is guaranteed service within MAX_WAIT+1 arbitration rounds.
- Stores never return read data: d_rdata = 0 on a store ack.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2
  - port-select encoding: SEL_IF=1'b0, SEL_D=1'b1
  - default MEM_SIZE and MAX_WAIT constants
- One sub-module, mem_addr_check (combinational): inputs addr and MEM_SIZE parameter; output fault.

Test Plan:
- Fetch-only load: after reset, if_req=1, if_addr=0x8, mem word 2=0x00500113 -> if_ack at cycle+2, if_rdata=0x00500113, if_err=0, mem_we never 1.
- Store then load: d_req, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> mem_we=1 for exactly one cycle, d_ack with d_rdata=0. Then a load from 0x20 -> d_rdata=0xDEADBEEF.
- Contention and starvation, MAX_WAIT=4: if_req and d_req held continuously -> grant order D,D,D,D,IF,D,D,D,D,IF; no ack ever overlaps for both ports.
- Faults: d_addr=0x22 store -> d_err=1, mem_we stays 0. if_addr=0x100 (word 64, MEM_SIZE=64) -> if_err=1, if_rdata=0.
- Reset mid-operation: rst_n=0 during the ACCESS cycle of a store to 0x30 -> word 12 unchanged, no d_ack. After release, d_req still high -> store completes normally.
- Idle behaviour: no requests for 10 cycles -> state stays IDLE, all acks 0, mem_we 0.
